// File: rtl/monostable_bank_if.sv
// Bus bundle for monostable_bank: clock enable, per-channel controls and
// the filtered level / pulse / sticky outputs.
interface monostable_bank_if #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned FILTER_BITS = 4
);
    logic                   clk_en;
    logic [CHANNELS-1:0]    monostable_en_i;
    logic [CHANNELS-1:0]    sense_i;
    logic [FILTER_BITS-1:0] filter_len_i;
    logic [CHANNELS-1:0]    sticky_clr_i;
    logic [CHANNELS-1:0]    state_o;
    logic [CHANNELS-1:0]    posedge_mono_o;
    logic [CHANNELS-1:0]    negedge_mono_o;
    logic [CHANNELS-1:0]    bothedge_mono_o;
    logic [CHANNELS-1:0]    sticky_o;
    logic                   any_sticky_o;

    modport master (
        output clk_en, monostable_en_i, sense_i, filter_len_i, sticky_clr_i,
        input  state_o, posedge_mono_o, negedge_mono_o, bothedge_mono_o, sticky_o, any_sticky_o
    );

    modport slave (
        input  clk_en, monostable_en_i, sense_i, filter_len_i, sticky_clr_i,
        output state_o, posedge_mono_o, negedge_mono_o, bothedge_mono_o, sticky_o, any_sticky_o
    );
endinterface

// File: rtl/monostable_bank.sv
// Multi-channel edge-pulse generator: optional synchroniser, debounce filter,
// one-shot edge pulses and sticky event flags per channel.
module monostable_bank #(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_BITS = 4,
    parameter bit          BUFFERED    = 1'b0
) (
    input logic              clk,
    input logic              async_rst,
    monostable_bank_if.slave bus
);
    logic [CHANNELS-1:0]    sampled;
    logic [CHANNELS-1:0]    level_q, level_d;
    logic [FILTER_BITS-1:0] count_q [CHANNELS];
    logic [FILTER_BITS-1:0] count_d [CHANNELS];
    logic [CHANNELS-1:0]    update;
    logic [CHANNELS-1:0]    pos_pulse, neg_pulse;
    logic [CHANNELS-1:0]    sticky_q, sticky_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sampled = bus.sense_i;
        end else begin : g_sync
            logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else if (bus.clk_en) begin
                    sync_q[0] <= bus.sense_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign sampled = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A level change needs filter_len_i+1 consecutive differing samples; the
    // counter stops at filter_len_i so it can never wrap.
    always_comb begin
        level_d = level_q;
        update  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            count_d[ch] = count_q[ch];
            if (bus.clk_en) begin
                if (!bus.monostable_en_i[ch]) begin
                    level_d[ch] = 1'b0;
                    count_d[ch] = '0;
                end else if (sampled[ch] == level_q[ch]) begin
                    count_d[ch] = '0;
                end else if (count_q[ch] < bus.filter_len_i) begin
                    count_d[ch] = count_q[ch] + 1'b1;
                end else begin
                    level_d[ch] = sampled[ch];
                    count_d[ch] = '0;
                    update[ch]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            level_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) count_q[ch] <= '0;
        end else begin
            level_q <= level_d;
            for (int ch = 0; ch < CHANNELS; ch++) count_q[ch] <= count_d[ch];
        end
    end

    assign pos_pulse = update & sampled;
    assign neg_pulse = update & ~sampled;

    // Clear acts on every edge; a simultaneous set wins.
    assign sticky_d = (sticky_q & ~bus.sticky_clr_i) | update;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) sticky_q <= '0;
        else           sticky_q <= sticky_d;
    end

    generate
        if (BUFFERED) begin : g_buf
            logic [CHANNELS-1:0] pos_q, neg_q, state_q;

            always_ff @(posedge clk or posedge async_rst) begin
                if (async_rst) begin
                    pos_q   <= '0;
                    neg_q   <= '0;
                    state_q <= '0;
                end else if (bus.clk_en) begin
                    pos_q   <= pos_pulse;
                    neg_q   <= neg_pulse;
                    state_q <= level_q;
                end
            end

            assign bus.posedge_mono_o = pos_q;
            assign bus.negedge_mono_o = neg_q;
            assign bus.state_o        = state_q;
        end else begin : g_comb
            assign bus.posedge_mono_o = pos_pulse;
            assign bus.negedge_mono_o = neg_pulse;
            assign bus.state_o        = level_q;
        end
    endgenerate

    assign bus.bothedge_mono_o = bus.posedge_mono_o | bus.negedge_mono_o;
    assign bus.sticky_o        = sticky_q;
    assign bus.any_sticky_o    = |sticky_q;
endmodule
